// File: rtl/spectro_serial_deserializer_pkg.sv
// Shared types and constants for the spectrometer serial deserializer.
package spectro_serial_deserializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int WORD_DIBITS = 4;
  localparam int DATA_W      = 7;
  localparam int DEF_CH_W    = 4;
  localparam int DEF_TIME_W  = 8;

  // FIFO entry layout at the default channel/time widths.
  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic [DEF_CH_W-1:0]   ch;
    logic [DEF_TIME_W-1:0] time_idx;
  } fifo_entry_t;

endpackage

// File: rtl/spectro_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is always on pop_data.
module spectro_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             wr_en_s;
  logic             rd_en_s;

  assign full     = (count_r == (AW+1)'(DEPTH));
  assign empty    = (count_r == '0);
  assign wr_en_s  = push & (~full | pop);
  assign rd_en_s  = pop & ~empty;
  assign pop_data = mem_r[rd_ptr_r];

  // Storage is cleared on reset so the head reads zero before any write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
    end else if (wr_en_s) begin
      mem_r[wr_ptr_r] <= push_data;
      wr_ptr_r        <= wr_ptr_r + AW'(1);
    end else begin
      wr_ptr_r <= wr_ptr_r;
    end
  end

  // Read pointer and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (rd_en_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      else         rd_ptr_r <= rd_ptr_r;
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/spectro_serial_deserializer.sv
// Assembles 4-dibit channel words into {amplitude, channel, time} entries and buffers them.
module spectro_serial_deserializer
  import spectro_serial_deserializer_pkg::*;
#(
  parameter int CH_W       = 4,
  parameter int TIME_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sending_data,
  input  logic [1:0]        serial_in,
  input  logic              sl_time,
  input  logic              sl_ch,
  input  logic              out_ready,
  input  logic              err_clr,
  output logic              out_valid,
  output logic [6:0]        out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic [TIME_W-1:0] out_time,
  output logic              overflow,
  output logic              framing_error
);
  localparam int ENTRY_W = DATA_W + CH_W + TIME_W;

  state_e              state_r, state_next;
  logic [1:0]          cnt_r;
  logic [7:0]          shreg_r;
  logic                done_r;
  logic [CH_W-1:0]     ch_r, ch_next, word_ch_r;
  logic [TIME_W-1:0]   time_r, time_next, word_time_r;
  logic                push_r;
  logic [ENTRY_W-1:0]  push_data_r;
  logic [ENTRY_W-1:0]  head_s;
  logic                load_s, shift_s, done_s, fsm_err_s;
  logic                ch_evt_s, time_only_s, pop_s, full_s, empty_s;

  assign ch_evt_s    = sending_data & sl_ch;
  assign time_only_s = sending_data & sl_time & ~sl_ch;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_r;
    case (state_r)
      IDLE: begin
        if (ch_evt_s) state_next = SHIFT;
        else          state_next = IDLE;
      end
      SHIFT: begin
        if (!sending_data)                          state_next = IDLE;
        else if (sl_ch)                             state_next = SHIFT;
        else if (cnt_r == 2'(WORD_DIBITS - 1))      state_next = IDLE;
        else                                        state_next = SHIFT;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: a marker inside a word restarts it at dibit 0 and flags an error.
  always_comb begin
    load_s    = 1'b0;
    shift_s   = 1'b0;
    done_s    = 1'b0;
    fsm_err_s = 1'b0;
    case (state_r)
      IDLE: begin
        load_s = ch_evt_s;
      end
      SHIFT: begin
        if (!sending_data) begin
          fsm_err_s = 1'b1;
        end else if (sl_ch) begin
          load_s    = 1'b1;
          fsm_err_s = 1'b1;
        end else begin
          shift_s = 1'b1;
          done_s  = (cnt_r == 2'(WORD_DIBITS - 1));
        end
      end
      default: begin
        load_s = 1'b0;
      end
    endcase
  end

  // Counter values after this cycle's markers.
  always_comb begin
    ch_next   = ch_r;
    time_next = time_r;
    if (ch_evt_s && sl_time) begin
      ch_next   = '0;
      time_next = time_r + TIME_W'(1);
    end else if (ch_evt_s) begin
      ch_next   = ch_r + CH_W'(1);
    end else begin
      ch_next   = ch_r;
    end
  end

  // Dibit shifter and word-tag capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_r     <= 8'h00;
      cnt_r       <= 2'd0;
      done_r      <= 1'b0;
      ch_r        <= '0;
      time_r      <= '1;
      word_ch_r   <= '0;
      word_time_r <= '0;
    end else begin
      ch_r   <= ch_next;
      time_r <= time_next;
      done_r <= done_s;
      if (load_s) begin
        shreg_r     <= {6'b000000, serial_in};
        cnt_r       <= 2'd1;
        word_ch_r   <= ch_next;
        word_time_r <= time_next;
      end else if (shift_s) begin
        shreg_r <= {shreg_r[5:0], serial_in};
        cnt_r   <= cnt_r + 2'd1;
      end else begin
        shreg_r <= shreg_r;
      end
    end
  end

  // Push stage: words with bit7 set never reach the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_r      <= 1'b0;
      push_data_r <= '0;
    end else begin
      push_r      <= done_r & ~shreg_r[7];
      push_data_r <= {shreg_r[6:0], word_ch_r, word_time_r};
    end
  end

  assign pop_s     = ~empty_s & out_ready;
  assign out_valid = ~empty_s;
  assign out_data  = head_s[ENTRY_W-1 -: DATA_W];
  assign out_ch    = head_s[TIME_W +: CH_W];
  assign out_time  = head_s[TIME_W-1:0];

  spectro_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_r),
    .push_data (push_data_r),
    .pop       (pop_s),
    .pop_data  (head_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  // Sticky flags; a set in the same cycle as err_clr takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      framing_error <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      if (fsm_err_s | time_only_s | (done_r & shreg_r[7])) framing_error <= 1'b1;
      else if (err_clr)                                    framing_error <= 1'b0;
      else                                                 framing_error <= framing_error;
      if (push_r & full_s & ~pop_s) overflow <= 1'b1;
      else if (err_clr)             overflow <= 1'b0;
      else                          overflow <= overflow;
    end
  end

endmodule

// File: tb/tb_spectro_serial_deserializer.sv
// Directed bench with a scoreboard of expected {data, ch, time} entries.
module tb_spectro_serial_deserializer;
  import spectro_serial_deserializer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sending_data = 1'b0;
  logic [1:0] serial_in = 2'b00;
  logic       sl_time = 1'b0;
  logic       sl_ch = 1'b0;
  logic       out_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic       out_valid;
  logic [6:0] out_data;
  logic [3:0] out_ch;
  logic [7:0] out_time;
  logic       overflow;
  logic       framing_error;

  int checks = 0;
  int errors = 0;
  fifo_entry_t sb[$];
  logic [3:0] exp_ch = 4'h0;
  logic [7:0] exp_time = 8'hFF;

  spectro_serial_deserializer #(.CH_W(4), .TIME_W(8), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sending_data  (sending_data),
    .serial_in     (serial_in),
    .sl_time       (sl_time),
    .sl_ch         (sl_ch),
    .out_ready     (out_ready),
    .err_clr       (err_clr),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ch        (out_ch),
    .out_time      (out_time),
    .overflow      (overflow),
    .framing_error (framing_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    sending_data = 1'b0;
    sl_ch        = 1'b0;
    sl_time      = 1'b0;
    serial_in    = 2'b00;
  endtask

  task automatic send_word(input bit st, input logic [7:0] w, input bit exp_push);
    if (st) begin
      exp_ch   = 4'h0;
      exp_time = exp_time + 8'h01;
    end else begin
      exp_ch = exp_ch + 4'h1;
    end
    if (exp_push && !w[7]) sb.push_back('{data: w[6:0], ch: exp_ch, time_idx: exp_time});
    for (int i = 0; i < 4; i++) begin
      sending_data = 1'b1;
      sl_ch        = (i == 0);
      sl_time      = (i == 0) && st;
      serial_in    = w[7-2*i -: 2];
      step(1);
    end
    idle();
  endtask

  task automatic send_partial(input int n);
    exp_ch = exp_ch + 4'h1;
    for (int i = 0; i < n; i++) begin
      sending_data = 1'b1;
      sl_ch        = (i == 0);
      sl_time      = 1'b0;
      serial_in    = 2'b01;
      step(1);
    end
  endtask

  task automatic clear_flags();
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
  endtask

  // Scoreboard: every word taken by the consumer must match the oldest expected entry.
  always @(negedge clk) begin
    fifo_entry_t e;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL spurious_word observed %0h expected none", {out_data, out_ch, out_time});
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        assert ({out_data, out_ch, out_time} === e) else begin
          errors++;
          $error("FAIL word observed %0h expected %0h", {out_data, out_ch, out_time}, e);
        end
      end
    end
  end

  initial begin
    #2;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 7'h00);
    chk("rst_ch", out_ch, 4'h0);
    chk("rst_time", out_time, 8'h00);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_ferr", framing_error, 1'b0);
    step(2);
    rst_n = 1'b1;
    step(1);

    // First slice, held at the output to check latency.
    send_word(1'b1, 8'h6C, 1'b1);
    step(1);
    chk("lat_not_yet", out_valid, 1'b0);
    step(1);
    chk("lat_valid", out_valid, 1'b1);
    chk("first_data", out_data, 7'h6C);
    chk("first_ch", out_ch, 4'h0);
    chk("first_time", out_time, 8'h00);
    step(2);
    chk("hold_data", out_data, 7'h6C);
    out_ready = 1'b1;
    step(2);

    send_word(1'b0, 8'h11, 1'b1);
    step(4);
    chk("no_ferr_yet", framing_error, 1'b0);

    // Overflow: five words into a four-deep buffer.
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_word(1'b0, 8'(i), i <= 4);
    step(3);
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    step(6);
    chk("drained", out_valid, 1'b0);
    chk("sb_after_drain", sb.size(), 0);
    clear_flags();
    chk("ovf_clr", overflow, 1'b0);

    // Channel marker after dibit 2 restarts the word.
    send_partial(3);
    send_word(1'b0, 8'h2A, 1'b1);
    chk("restart_ferr", framing_error, 1'b1);
    step(4);
    clear_flags();
    chk("ferr_clr1", framing_error, 1'b0);

    // Word with bit7 set is discarded.
    send_word(1'b0, 8'h80, 1'b0);
    step(3);
    chk("bit7_ferr", framing_error, 1'b1);
    chk("bit7_no_push", out_valid, 1'b0);
    clear_flags();
    chk("ferr_clr2", framing_error, 1'b0);

    // Stream drop mid-word.
    send_partial(2);
    idle();
    step(1);
    chk("drop_ferr", framing_error, 1'b1);
    clear_flags();

    // Time marker without channel marker leaves counters alone.
    sending_data = 1'b1;
    sl_time      = 1'b1;
    step(1);
    idle();
    chk("lone_time_ferr", framing_error, 1'b1);
    clear_flags();
    send_word(1'b0, 8'h55, 1'b1);
    step(4);

    // Set wins over a simultaneous clear.
    sending_data = 1'b1;
    sl_time      = 1'b1;
    err_clr      = 1'b1;
    step(1);
    idle();
    err_clr = 1'b0;
    chk("set_beats_clr", framing_error, 1'b1);
    clear_flags();

    // 256 slices: time index wraps 255 -> 0.
    for (int i = 0; i < 256; i++) send_word(1'b1, {1'b0, 7'(i)}, 1'b1);
    step(4);
    chk("sb_after_wrap", sb.size(), 0);
    chk("wrap_time_model", exp_time, 8'h00);

    // Reset mid-word.
    send_partial(2);
    rst_n = 1'b0;
    idle();
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_data", out_data, 7'h00);
    chk("mid_rst_time", out_time, 8'h00);
    chk("mid_rst_ferr", framing_error, 1'b0);
    exp_ch   = 4'h0;
    exp_time = 8'hFF;
    step(1);
    rst_n = 1'b1;
    step(6);
    chk("post_rst_valid", out_valid, 1'b0);
    send_word(1'b1, 8'h33, 1'b1);
    step(4);
    chk("sb_final", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL timeout observed running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spectro_serial_deserializer.md
SPECTRO_SERIAL_DESERIALIZER -- requirements
Module: spectro_serial_deserializer

Interface
REQ-001 SHALL have parameter CH_W, default 4, channel-index width.
REQ-002 SHALL have parameter TIME_W, default 8, time-slice-index width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port sending_data  input  1  stream-active qualifier from the extractor.
REQ-007 SHALL have port serial_in  input  2  dibit per clk, serial_in[1] is the more significant bit.
REQ-008 SHALL have port sl_time  input  1  start-of-time-slice marker.
REQ-009 SHALL have port sl_ch  input  1  start-of-channel-word marker.
REQ-010 SHALL have port out_ready  input  1  consumer accepts word.
REQ-011 SHALL have port err_clr  input  1  clears sticky flags.
REQ-012 SHALL have port out_valid  output  1  word available.
REQ-013 SHALL have port out_data  output  7  channel amplitude.
REQ-014 SHALL have port out_ch  output  CH_W  channel index of out_data.
REQ-015 SHALL have port out_time  output  TIME_W  time-slice index of out_data.
REQ-016 SHALL have port overflow  output  1  sticky, word dropped on full FIFO.
REQ-017 SHALL have port framing_error  output  1  sticky, malformed stream.

Function
REQ-018 Word format: 8 bits = 4 dibits, MSB dibit first; bit7 SHALL be 0, bits6:0 = amplitude.
REQ-019 Markers/dibits SHALL be sampled only in cycles with sending_data=1; sl_time/sl_ch ignored otherwise.
REQ-020 FSM states: IDLE, SHIFT. IDLE->SHIFT on sl_ch=1 (that cycle's dibit = dibit 0); SHIFT->IDLE after dibit 3 captured.
REQ-021 In SHIFT, sl_ch=1 on dibit 1..3 SHALL discard partial word, set framing_error, restart at dibit 0.
REQ-022 In SHIFT, sending_data=0 SHALL discard partial word, set framing_error, go IDLE.
REQ-023 Channel counter: +1 on each sl_ch; cleared to 0 when sl_ch and sl_time coincide; wraps mod 2^CH_W.
REQ-024 Time counter: +1 on sl_time; reset value all-ones so first slice is 0; wraps mod 2^TIME_W.
REQ-025 sl_time without sl_ch in same cycle SHALL set framing_error, leave counters unchanged.
REQ-026 Completed word with bit7=1 SHALL be discarded and set framing_error.
REQ-027 Valid word {amplitude, ch, time} SHALL be pushed in the cycle after dibit 3 is captured; out_valid visible the cycle after push when FIFO was empty (2 clk from dibit 3 edge).
REQ-028 Pop SHALL occur when out_valid && out_ready; outputs show FIFO head, first-word-fall-through.
REQ-029 Push on full FIFO without simultaneous pop SHALL drop the word and set overflow; push with pop on full SHALL succeed.
REQ-030 Push and pop on empty FIFO: word SHALL be stored, not bypassed.
REQ-031 out_data/out_ch/out_time SHALL hold stable while out_valid=1 and out_ready=0.
REQ-032 err_clr SHALL clear overflow and framing_error next edge; a simultaneous set event SHALL win.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE, FIFO empty, out_valid=0, out_data=0, out_ch=0, out_time=0, overflow=0, framing_error=0, channel counter 0, time counter all-ones.
REQ-034 Reset mid-word SHALL discard the partial word; no push after release.

Structure
REQ-035 Shared package SHALL hold FSM state enum, WORD_DIBITS=4, and the FIFO entry struct {data, ch, time}.
REQ-036 FIFO SHALL be a separate sub-module spectro_sync_fifo (depth, width parameters, full/empty).

Verification
REQ-037 Reset then slice: sl_time+sl_ch, dibits 01,10,11,00 -> out_data=0x6C? no: word 0x6C has bit7=0 -> out_data=7'h6C, out_ch=0, out_time=0, valid 2 clk after last dibit.
REQ-038 Two channels, second sl_ch alone, dibits 00,01,00,01 -> out_data=7'h11, out_ch=1, out_time=0.
REQ-039 out_ready=0, 5 words -> 4 buffered, overflow=1, then drain yields first 4 in order.
REQ-040 sl_ch after dibit 2 -> framing_error=1, partial dropped, following word delivered intact.
REQ-041 Word 0x80 (dibits 10,00,00,00) -> no push, framing_error=1; err_clr -> flags 0.
REQ-042 256 slices -> out_time wraps 255->0; rst_n pulse mid-word -> all outputs at reset values, no spurious word.
